// File: rtl/div_restoring.sv
// -----------------------------------------------------------------------------
// div_restoring -- sequential unsigned restoring divider, one quotient bit per
// clock.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst        : synchronous, active-high reset
//   start      : request a division (accepted only while idle)
//   A, B       : dividend / divisor, sampled only on the accepting edge
//   q, r       : quotient / remainder, registered, valid from the done cycle
//   busy       : high while the divider is iterating
//   done       : one-cycle pulse when q, r and dbz carry a fresh result
//   dbz        : divide-by-zero flag of the most recent result
//   fsm_state  : current FSM state for observation (0 IDLE, 1 CALC, 2 DONE)
//
// Handshake: start is a request that is taken on a rising edge only when
// fsm_state is IDLE; there is no back-pressure beyond that, so a start seen in
// CALC or DONE is dropped and its operands are never sampled. The response is
// the done pulse. A non-zero divisor gives done N+1 cycles after acceptance;
// a zero divisor gives done on the next cycle with q = all ones, r = A.
// Results hold until the next done, even while a new division is running.
// -----------------------------------------------------------------------------
module div_restoring #(
    parameter int DATA_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic [DATA_WIDTH-1:0] q,
    output logic [DATA_WIDTH-1:0] r,
    output logic                  busy,
    output logic                  done,
    output logic                  dbz,
    output logic [1:0]            fsm_state
);

    localparam int N  = DATA_WIDTH;
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [N-1:0]  dvd;      // dividend, shifted out MSB first
    logic [N-1:0]  dvs;      // latched divisor
    logic [N-1:0]  rem;      // working remainder; always < divisor, so N bits hold it
    logic [N-1:0]  quo;      // quotient bits shifted in LSB first
    logic [CW-1:0] cnt;      // step index within CALC

    // One restoring step. The shifted remainder can reach 2*B-1, so the
    // shift and trial subtraction are done at N+1 bits; bit N of the trial
    // is the borrow, set exactly when the divisor does not fit.
    logic [N:0]   rem_sh;
    logic [N:0]   trial;
    logic         fits;
    logic [N-1:0] rem_next;
    logic [N-1:0] quo_next;

    always_comb begin
        rem_sh   = {rem, dvd[N-1]};
        trial    = rem_sh - {1'b0, dvs};
        fits     = ~trial[N];
        rem_next = fits ? trial[N-1:0] : rem_sh[N-1:0];
        quo_next = {quo[N-2:0], fits};
    end

    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            q     <= '0;
            r     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            dbz   <= 1'b0;
            dvd   <= '0;
            dvs   <= '0;
            rem   <= '0;
            quo   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        if (B == '0) begin
                            // Division by zero bypasses the iteration.
                            q     <= '1;
                            r     <= A;
                            dbz   <= 1'b1;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            dvd   <= A;
                            dvs   <= B;
                            rem   <= '0;
                            quo   <= '0;
                            cnt   <= '0;
                            busy  <= 1'b1;
                            state <= CALC;
                        end
                    end
                end

                CALC: begin
                    dvd <= {dvd[N-2:0], 1'b0};
                    rem <= rem_next;
                    quo <= quo_next;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST_STEP) begin
                        // Last step: publish the result straight from the
                        // step logic so done follows on the next cycle.
                        q     <= quo_next;
                        r     <= rem_next;
                        dbz   <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_restoring.sv
// -----------------------------------------------------------------------------
// tb_div_restoring -- bench for div_restoring at DATA_WIDTH 4 and 8.
// Expected results come from plain integer division and are queued when a
// division is issued; one monitor per instance pops an entry on every done
// pulse and compares.
// -----------------------------------------------------------------------------
module tb_div_restoring;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // ---------------- DUT N=4 ----------------
    logic       start4;
    logic [3:0] a4, b4, q4, r4;
    logic       busy4, done4, dbz4;
    logic [1:0] st4;

    div_restoring #(.DATA_WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .start(start4), .A(a4), .B(b4),
        .q(q4), .r(r4), .busy(busy4), .done(done4), .dbz(dbz4),
        .fsm_state(st4)
    );

    // ---------------- DUT N=8 ----------------
    logic       start8;
    logic [7:0] a8, b8, q8, r8;
    logic       busy8, done8, dbz8;
    logic [1:0] st8;

    div_restoring #(.DATA_WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8),
        .q(q8), .r(r8), .busy(busy8), .done(done8), .dbz(dbz8),
        .fsm_state(st8)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [8:0]  exp4_q[$];   // {dbz, q, r}
    logic [16:0] exp8_q[$];

    function automatic logic [8:0] model4(input logic [3:0] a, input logic [3:0] b);
        if (b == 0) return {1'b1, 4'hF, a};
        return {1'b0, 4'(a / b), 4'(a % b)};
    endfunction

    function automatic logic [16:0] model8(input logic [7:0] a, input logic [7:0] b);
        if (b == 0) return {1'b1, 8'hFF, a};
        return {1'b0, 8'(a / b), 8'(a % b)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // monitors
    always @(negedge clk) begin
        if (done4 === 1'b1) begin
            checks++;
            if (exp4_q.size() == 0) begin
                errors++;
                $display("FAIL u4_unexpected_done: got done with q=%0d r=%0d, expected no done", q4, r4);
            end else begin
                logic [8:0] e;
                e = exp4_q.pop_front();
                if ({dbz4, q4, r4} !== e) begin
                    errors++;
                    $display("FAIL u4_result: got dbz=%0b q=%0d r=%0d expected dbz=%0b q=%0d r=%0d",
                             dbz4, q4, r4, e[8], e[7:4], e[3:0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            checks++;
            if (exp8_q.size() == 0) begin
                errors++;
                $display("FAIL u8_unexpected_done: got done with q=%0d r=%0d, expected no done", q8, r8);
            end else begin
                logic [16:0] e;
                e = exp8_q.pop_front();
                if ({dbz8, q8, r8} !== e) begin
                    errors++;
                    $display("FAIL u8_result: got dbz=%0b q=%0d r=%0d expected dbz=%0b q=%0d r=%0d",
                             dbz8, q8, r8, e[16], e[15:8], e[7:0]);
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic issue4(input logic [3:0] a, input logic [3:0] b, input bit push);
        @(negedge clk);
        a4 = a; b4 = b; start4 = 1'b1;
        if (push) exp4_q.push_back(model4(a, b));
        @(posedge clk);
        #1 start4 = 1'b0;
    endtask

    task automatic issue8(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        a8 = a; b8 = b; start8 = 1'b1;
        exp8_q.push_back(model8(a, b));
        @(posedge clk);
        #1 start8 = 1'b0;
    endtask

    // Counts negedges until done (1 = first negedge after the accepting edge).
    task automatic wait4(output int lat, output int busy_n);
        lat = 0; busy_n = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (busy4) busy_n++;
            if (done4) begin lat = i; break; end
        end
        if (lat == 0) begin
            checks++; errors++;
            $display("FAIL wait4_timeout: got no done within 100 cycles, expected done");
        end
    endtask

    task automatic wait8(output int lat);
        lat = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (done8) begin lat = i; break; end
        end
        if (lat == 0) begin
            checks++; errors++;
            $display("FAIL wait8_timeout: got no done within 100 cycles, expected done");
        end
    endtask

    // ---------------- stimulus ----------------
    int lat, bn;

    initial begin
        rst = 1'b1;
        start4 = 1'b0; a4 = '0; b4 = '0;
        start8 = 1'b0; a8 = '0; b8 = '0;
        repeat (3) @(negedge clk);
        check("reset4_outputs", {19'd0, q4, r4, busy4, done4, dbz4, st4}, 0);
        check("reset8_outputs", {11'd0, q8, r8, busy8, done8, dbz8, st8}, 0);
        rst = 1'b0;

        // 13/3: latency and busy length
        issue4(4'd13, 4'd3, 1'b1);
        wait4(lat, bn);
        check("lat_13_3", lat, 5);
        check("busy_13_3", bn, 4);

        // assorted operands, all with full latency
        issue4(4'd2, 4'd7, 1'b1);   wait4(lat, bn); check("lat_2_7", lat, 5);
        issue4(4'd15, 4'd1, 1'b1);  wait4(lat, bn); check("lat_15_1", lat, 5);
        issue4(4'd15, 4'd15, 1'b1); wait4(lat, bn); check("lat_15_15", lat, 5);
        issue4(4'd0, 4'd5, 1'b1);   wait4(lat, bn); check("lat_0_5", lat, 5);

        // divide by zero, then results held while the next division runs
        issue4(4'd9, 4'd0, 1'b1);
        wait4(lat, bn);
        check("lat_dbz", lat, 1);
        check("busy_dbz", bn, 0);
        issue4(4'd9, 4'd3, 1'b1);
        @(negedge clk);
        check("hold_during_calc", {23'd0, dbz4, q4, r4}, {23'd0, 1'b1, 4'd15, 4'd9});
        wait4(lat, bn);
        check("lat_9_3", lat, 4);

        // start pulsed during CALC must be ignored
        issue4(4'd13, 4'd3, 1'b1);
        @(negedge clk);
        a4 = 4'd1; b4 = 4'd1; start4 = 1'b1;
        @(posedge clk);
        #1 start4 = 1'b0;
        wait4(lat, bn);
        check("lat_ignored_start", lat, 4);
        repeat (8) @(negedge clk);
        check("no_extra_done", exp4_q.size(), 0);

        // reset during the second CALC cycle discards the division
        issue4(4'd13, 4'd3, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midcalc_reset", {19'd0, q4, r4, busy4, done4, dbz4, st4}, 0);
        repeat (8) @(negedge clk);
        issue4(4'd6, 4'd4, 1'b1);
        wait4(lat, bn);
        check("lat_after_reset", lat, 5);

        // reset wins over start on the same edge
        @(negedge clk);
        rst = 1'b1; a4 = 4'd5; b4 = 4'd1; start4 = 1'b1;
        @(posedge clk);
        #1 begin rst = 1'b0; start4 = 1'b0; end
        @(negedge clk);
        check("rst_over_start", {29'd0, busy4, st4}, 0);

        // N=8 back-to-back issue at the first idle edge after done
        issue8(8'd255, 8'd16);
        wait8(lat);
        check("lat8_255_16", lat, 9);
        issue8(8'd200, 8'd7);
        wait8(lat);
        check("lat8_200_7", lat, 9);

        // N=8 corners
        issue8(8'd0, 8'd5);     wait8(lat);
        issue8(8'd3, 8'd200);   wait8(lat);
        issue8(8'd77, 8'd1);    wait8(lat);
        issue8(8'd255, 8'd255); wait8(lat);
        issue8(8'd100, 8'd0);   wait8(lat); check("lat8_dbz", lat, 1);

        // N=8 random
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] a, b;
            a = 8'($urandom_range(0, 255));
            case ($urandom_range(0, 15))
                0:       b = 8'd0;
                1, 2, 3: b = 8'($urandom_range(1, 15));
                default: b = 8'($urandom_range(1, 255));
            endcase
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue8(a, b);
            wait8(lat);
            check("lat8_random", lat, (b == 0) ? 1 : 9);
        end

        repeat (4) @(negedge clk);
        check("exp4_drained", exp4_q.size(), 0);
        check("exp8_drained", exp8_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
